uart_byte_rx: RTL and testbench

- Asynchronous serial receiver (8N1, LSB first) feeding the PC-command path of the PCB control design.
- Converts the host UART line into byte strobes, `rx_done` plus `rx_data_out`, consumed directly by the row/column shift-register state machine.
- That state machine takes two bytes per command: column, then row.
- Adds line-idle arming, majority-vote bit sampling and framing-error reporting so that a glitchy or mid-frame line never produces a false command byte.

---
 rtl/uart_byte_rx_if.sv | 12 +
 rtl/uart_byte_rx.sv | 157 +++++++++++++++
 tb/tb_uart_byte_rx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_byte_rx_if.sv
// Receiver-side signal bundle: the serial line in, byte strobes and status out.
interface uart_byte_rx_if;
  logic       rx;
  logic       rx_done;
  logic [7:0] rx_data_out;
  logic       frame_err;
  logic       rx_busy;

  // master drives the line and consumes bytes; slave is the receiver
  modport master (output rx, input rx_done, rx_data_out, frame_err, rx_busy);
  modport slave  (input rx, output rx_done, rx_data_out, frame_err, rx_busy);
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 LSB-first UART byte receiver with line-idle arming, 3-sample majority
// voting around each bit centre and framing-error reporting.
//
// state | meaning
// ARM   | wait for CPB consecutive high cycles before trusting the line
// IDLE  | line idle, waiting for the falling edge of a start bit
// START | timing the start bit, rejecting it if the vote says high
// DATA  | assembling 8 data bits LSB first
// STOP  | voting the stop bit; deliver byte or flag a framing error
module uart_byte_rx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic          clk,
  input  logic          reset,
  uart_byte_rx_if.slave bus
);
  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  localparam logic [CW-1:0] CNT_LAST   = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_EARLY  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_MID    = CW'(HALF);
  localparam logic [CW-1:0] CNT_DECIDE = CW'(HALF + 1);

  if (CPB < 8) begin : g_cpb_check
    $error("uart_byte_rx: CLK_HZ/BAUD must be at least 8");
  end

  typedef enum logic [2:0] {ST_ARM, ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          smp0_q, smp0_d;
  logic          smp1_q, smp1_d;
  logic          rx_s1_q, rx_s2_q;
  logic          at_decide;
  logic          vote;

  // two-flop synchronizer for the asynchronous line; idles high out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= bus.rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  // the third vote is the live synchronized sample at the decision cycle
  assign at_decide = (cnt_q == CNT_DECIDE);
  assign vote      = (smp0_q & smp1_q) | (smp0_q & rx_s2_q) | (smp1_q & rx_s2_q);

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ARM;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      smp0_q  <= 1'b0;
      smp1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      smp0_q  <= smp0_d;
      smp1_q  <= smp1_d;
    end
  end

  // next-state, bit timing, sampling and strobe generation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    smp0_d  = smp0_q;
    smp1_d  = smp1_q;

    if (cnt_q == CNT_EARLY) smp0_d = rx_s2_q;
    if (cnt_q == CNT_MID)   smp1_d = rx_s2_q;

    case (state_q)
      ST_ARM: begin
        if (!rx_s2_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s2_q) state_d = ST_START;
      end
      ST_START: begin
        if (at_decide && vote) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (at_decide) shreg_d = {vote, shreg_q[7:1]};
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      ST_STOP: begin
        // leave at the decision point so a back-to-back start edge is not missed
        if (at_decide) begin
          cnt_d = '0;
          if (vote) begin
            data_d  = shreg_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_ARM;
          end
        end
      end
      default: begin
        state_d = ST_ARM;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.rx_done     = done_q;
  assign bus.frame_err   = ferr_q;
  assign bus.rx_data_out = data_q;
  assign bus.rx_busy     = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at CPB=10.
module tb_uart_byte_rx;
  localparam int CLK_HZ = 10_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;

  logic clk = 1'b0;
  logic reset;
  uart_byte_rx_if bus();

  uart_byte_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int frame_cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int both_seen = 0;
  logic [7:0] got_q[$];
  int got_cyc[$];
  logic busy_mid;

  always @(posedge clk) cyc <= cyc + 1;

  // strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.rx_done) begin
      done_cnt++;
      got_q.push_back(bus.rx_data_out);
      got_cyc.push_back(cyc);
    end
    if (bus.frame_err) ferr_cnt++;
    if (bus.rx_done && bus.frame_err) both_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.rx = 1'b1;
    end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.rx = 1'b0;
    end
  endtask

  // one 10-bit frame; glitch_c >= 0 inverts the line for that single cycle
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_c);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      @(posedge clk); #1;
      if (c == 0) frame_cyc = cyc;
      if (c == 5 * CPB) busy_mid = bus.rx_busy;
      bus.rx = f[c / CPB] ^ (c == glitch_c);
    end
  endtask

  function automatic logic [7:0] byte_at(input int k);
    return (got_q.size() > k) ? got_q[k] : 8'hxx;
  endfunction

  function automatic int cyc_at(input int k);
    return (got_cyc.size() > k) ? got_cyc[k] : -1;
  endfunction

  int d0, f0, k0;

  initial begin
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", bus.rx_done, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_data", bus.rx_data_out, 8'h00);
    check("rst_busy", bus.rx_busy, 0);
    reset = 1'b0;
    idle(2 * CPB);

    // single byte with latency measured from the edge that first samples rx low
    d0 = done_cnt; f0 = ferr_cnt; k0 = got_q.size();
    send_frame(8'h05, 1'b1, -1);
    idle(2 * CPB);
    check("t1_count", done_cnt - d0, 1);
    check("t1_data", byte_at(k0), 8'h05);
    check("t1_ferr", ferr_cnt - f0, 0);
    check("t1_busy_mid", busy_mid, 1);
    check("t1_latency", cyc_at(k0) - (frame_cyc + 1), 9 * CPB + HALF + 2 + 2);

    // back-to-back column/row pair
    d0 = done_cnt; k0 = got_q.size();
    send_frame(8'h1E, 1'b1, -1);
    send_frame(8'h03, 1'b1, -1);
    idle(2 * CPB);
    check("t2_count", done_cnt - d0, 2);
    check("t2_col", byte_at(k0), 8'h1E);
    check("t2_row", byte_at(k0 + 1), 8'h03);
    check("t2_spacing", cyc_at(k0 + 1) - cyc_at(k0), 10 * CPB);

    // 3-cycle start glitch must be rejected, then a real byte
    d0 = done_cnt; f0 = ferr_cnt;
    hold_low(3);
    idle(2 * CPB);
    check("t3_glitch_done", done_cnt - d0, 0);
    check("t3_glitch_ferr", ferr_cnt - f0, 0);
    check("t3_glitch_busy", bus.rx_busy, 0);
    k0 = got_q.size();
    send_frame(8'hA5, 1'b1, -1);
    idle(2 * CPB);
    check("t3_count", done_cnt - d0, 1);
    check("t3_data", byte_at(k0), 8'hA5);

    // framing error followed by a long break
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hFF, 1'b0, -1);
    hold_low(20 * CPB);
    check("t4_ferr", ferr_cnt - f0, 1);
    check("t4_done", done_cnt - d0, 0);
    check("t4_data_held", bus.rx_data_out, 8'hA5);
    idle(2 * CPB);
    k0 = got_q.size();
    send_frame(8'h12, 1'b1, -1);
    idle(2 * CPB);
    check("t4_count", done_cnt - d0, 1);
    check("t4_data", byte_at(k0), 8'h12);

    // reset lands on the final cycle of the receiver's bit-4 window; the line
    // then stays high for only CPB-1 armed cycles before bit 6 pulls it low,
    // so the rest of 0x3C cannot be re-framed
    d0 = done_cnt; f0 = ferr_cnt;
    fork
      send_frame(8'h3C, 1'b1, -1);
      begin
        repeat (63) @(posedge clk);
        #1;
        check("t5_busy_pre", bus.rx_busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_rst_done", bus.rx_done, 0);
        check("t5_rst_ferr", bus.frame_err, 0);
        check("t5_rst_data", bus.rx_data_out, 8'h00);
        check("t5_rst_busy", bus.rx_busy, 0);
      end
    join
    idle(2 * CPB);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_no_ferr", ferr_cnt - f0, 0);
    k0 = got_q.size();
    send_frame(8'h07, 1'b1, -1);
    idle(2 * CPB);
    check("t5_count", done_cnt - d0, 1);
    check("t5_data", byte_at(k0), 8'h07);

    // inverted pulse on the centre sample of data bit 2
    d0 = done_cnt; k0 = got_q.size();
    send_frame(8'h55, 1'b1, 3 * CPB + HALF + 1);
    idle(2 * CPB);
    check("t6_count", done_cnt - d0, 1);
    check("t6_data", byte_at(k0), 8'h55);

    check("strobe_overlap", both_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
